// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: branch/jump/hazard inputs and fetch-address outputs of the PC stage
interface pc_fetch_unit_if;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Stall;
  logic        Halt;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        Flush;
  logic        Halted;
  logic        MisalignErr;
  modport master (
    output BranchTaken, BranchTarget, Jump, JumpTarget, Stall, Halt,
    input  PC, PCPlus4, InstrValid, Flush, Halted, MisalignErr
  );
  modport slave (
    input  BranchTaken, BranchTarget, Jump, JumpTarget, Stall, Halt,
    output PC, PCPlus4, InstrValid, Flush, Halted, MisalignErr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with redirect, stall, halt and fixed-length flush window
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);
  localparam logic [1:0] START  = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, flush_q, flush_d, halted_q, halted_d, err_q, err_d;
  logic        active, redirect;
  logic [31:0] target, pc_inc;
  assign active   = (state_q == RUN) || (state_q == FLUSH);
  assign redirect = active && (bus.BranchTaken || bus.Jump);
  assign target   = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
  assign pc_inc   = pc_q + 32'd4;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    flush_d  = flush_q;
    halted_d = halted_q;
    err_d    = err_q;
    if (state_q == START) begin
      state_d = RUN;
      valid_d = 1'b1;
    end else if (redirect) begin
      state_d = FLUSH;
      pc_d    = {target[31:2], 2'b00};
      cnt_d   = FLUSH_LOAD;
      flush_d = 1'b1;
      valid_d = 1'b0;
      err_d   = err_q | (target[1:0] != 2'b00);
    end else if (active && !bus.Stall) begin
      // A halt seen during FLUSH belongs to the wrong path, so only RUN honours it
      if (state_q == RUN && bus.Halt) begin
        state_d  = HALTED;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end else if (state_q == RUN) begin
        pc_d = pc_inc;
      end else begin
        pc_d    = pc_inc;
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RUN : FLUSH;
        flush_d = cnt_q != 3'd1;
        valid_d = cnt_q == 3'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= START;
      pc_q     <= RESET_PC;
      cnt_q    <= 3'd0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end
  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_inc;
  assign bus.InstrValid  = valid_q;
  assign bus.Flush       = flush_q;
  assign bus.Halted      = halted_q;
  assign bus.MisalignErr = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table, wrap sequence and randomized run against a reference model
module tb_pc_fetch_unit;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, bt; logic [31:0] btt; logic j; logic [31:0] jt; logic st, h;
    logic [31:0] pc; logic v, f, hl, e;
  } vec_t;
  vec_t vq[$];
  bit m_started, m_halted, m_err;
  int m_bubbles;
  logic [31:0] m_pc;
  function automatic void add(logic rst, bt, logic [31:0] btt, logic j, logic [31:0] jt,
                              logic st, h, logic [31:0] pc, logic v, f, hl, e);
    vec_t x;
    x = '{rst, bt, btt, j, jt, st, h, pc, v, f, hl, e};
    vq.push_back(x);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic cmp_all(string tag, logic [31:0] pc, logic v, f, hl, e);
    chk({tag, " PC"}, bus.PC, pc);
    chk({tag, " PCPlus4"}, bus.PCPlus4, pc + 32'd4);
    chk({tag, " InstrValid"}, 32'(bus.InstrValid), 32'(v));
    chk({tag, " Flush"}, 32'(bus.Flush), 32'(f));
    chk({tag, " Halted"}, 32'(bus.Halted), 32'(hl));
    chk({tag, " MisalignErr"}, 32'(bus.MisalignErr), 32'(e));
  endtask
  task automatic drive(logic rst, bt, logic [31:0] btt, logic j, logic [31:0] jt, logic st, h);
    reset = rst; bus.BranchTaken = bt; bus.BranchTarget = btt;
    bus.Jump = j; bus.JumpTarget = jt; bus.Stall = st; bus.Halt = h;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Reference model: fetch is live once started, bubbles counts flush cycles still to show
  function automatic void model_step(logic rst, bt, logic [31:0] btt, logic j, logic [31:0] jt, logic st, h);
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0; m_started = 0; m_halted = 0; m_bubbles = 0; m_err = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_halted) begin
    end else if (bt || j) begin
      t = bt ? btt : jt;
      if (t % 4 != 0) m_err = 1;
      m_pc = t - (t % 4);
      m_bubbles = FC;
    end else if (st) begin
    end else if (m_bubbles == 0 && h) begin
      m_halted = 1;
    end else begin
      m_pc = m_pc + 32'd4;
      if (m_bubbles > 0) m_bubbles--;
    end
  endfunction
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    add(1,0,0,0,0,0,0, 32'h0,0,0,0,0);
    add(0,0,0,0,0,0,0, 32'h0,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h4,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h8,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'hC,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h10,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h14,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h18,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h1C,1,0,0,0);
    add(0,0,0,0,0,0,0, 32'h20,1,0,0,0);
    add(0,1,32'h100,0,0,0,0, 32'h100,0,1,0,0);
    add(0,0,0,0,0,0,0, 32'h104,0,1,0,0);
    add(0,0,0,0,0,0,0, 32'h108,1,0,0,0);
    add(0,1,32'h40,1,32'h80,1,0, 32'h40,0,1,0,0);
    add(0,1,32'h200,0,0,0,0, 32'h200,0,1,0,0);
    add(0,0,0,0,0,0,0, 32'h204,0,1,0,0);
    add(0,0,0,0,0,0,0, 32'h208,1,0,0,0);
    add(0,0,0,1,32'h103,0,0, 32'h100,0,1,0,1);
    add(0,0,0,0,0,0,0, 32'h104,0,1,0,1);
    add(0,0,0,0,0,0,1, 32'h108,1,0,0,1);
    add(0,0,0,0,0,1,0, 32'h108,1,0,0,1);
    add(0,1,32'h28,0,0,0,0, 32'h28,0,1,0,1);
    add(0,0,0,0,0,1,0, 32'h28,0,1,0,1);
    add(0,0,0,0,0,0,0, 32'h2C,0,1,0,1);
    add(0,0,0,0,0,0,0, 32'h30,1,0,0,1);
    add(0,0,0,0,0,0,1, 32'h30,0,0,1,1);
    add(0,1,32'h400,1,32'h500,0,0, 32'h30,0,0,1,1);
    add(0,0,0,1,32'h500,0,0, 32'h30,0,0,1,1);
    add(1,0,0,0,0,0,0, 32'h0,0,0,0,0);
    add(0,0,0,0,0,0,0, 32'h0,1,0,0,0);
    add(0,0,0,1,32'h40,0,0, 32'h40,0,1,0,0);
    add(1,0,0,0,0,0,0, 32'h0,0,0,0,0);
    add(0,0,0,0,0,0,0, 32'h0,1,0,0,0);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].bt, vq[i].btt, vq[i].j, vq[i].jt, vq[i].st, vq[i].h);
      tick();
      cmp_all($sformatf("vec%0d", i), vq[i].pc, vq[i].v, vq[i].f, vq[i].hl, vq[i].e);
    end
    drive(0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0);
    tick(); cmp_all("wrap0", 32'hFFFF_FFF0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); cmp_all("wrap1", 32'hFFFF_FFF4, 0, 1, 0, 0);
    tick(); cmp_all("wrap2", 32'hFFFF_FFF8, 1, 0, 0, 0);
    tick(); cmp_all("wrap3", 32'hFFFF_FFFC, 1, 0, 0, 0);
    chk("wrap PCPlus4 zero", bus.PCPlus4, 32'h0);
    tick(); cmp_all("wrap4", 32'h0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    tick(); cmp_all("rnd reset", m_pc, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic rst, bt, j, st, h;
      logic [31:0] btt, jt;
      rst = $urandom_range(99) < 2;
      bt  = $urandom_range(9) == 0;
      j   = $urandom_range(9) == 0;
      st  = $urandom_range(4) == 0;
      h   = $urandom_range(29) == 0;
      btt = $urandom; jt = $urandom;
      if ($urandom_range(7) != 0) btt[1:0] = 2'b00;
      if ($urandom_range(7) != 0) jt[1:0] = 2'b00;
      drive(rst, bt, btt, j, jt, st, h);
      model_step(rst, bt, btt, j, jt, st, h);
      tick();
      cmp_all($sformatf("rnd%0d", n), m_pc, m_started && !m_halted && m_bubbles == 0,
              m_bubbles > 0, m_halted, m_err);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage; consumes the branch-resolution decision (BranchTaken) from EX together with branch/jump targets.
- Drives the instruction-memory address and a fetch-valid qualifier.
- On a redirect, issues a flush for a fixed number of bubble cycles, so that wrong-path instructions are squashed before they reach EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of bubble cycles after a redirect (range 1..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- BranchTaken  input  1  conditional branch resolved taken in EX this cycle.
- BranchTarget  input  32  byte address for a taken branch.
- Jump  input  1  unconditional jump request from ID.
- JumpTarget  input  32  byte address for a jump.
- Stall  input  1  hazard-unit hold request; freezes PC.
- Halt  input  1  halt instruction decoded; stops fetch.
- PC  output  32  current fetch address (registered).
- PCPlus4  output  32  PC + 4, combinational from PC, modulo 2^32.
- InstrValid  output  1  fetched word at PC is on the correct path (registered).
- Flush  output  1  squash IF/ID and ID/EX contents this cycle (registered).
- Halted  output  1  fetch stopped (registered).
- MisalignErr  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Behaviour:
- **Reset** (reset=1 at an edge, overrides all other inputs, including mid-flush or halted):
  - PC=RESET_PC, state=START, InstrValid=0, Flush=0, Halted=0, MisalignErr=0, flush counter=0.
- **States:** START, RUN, FLUSH, HALTED.
- **START:**
  - Lasts one cycle, PC held.
  - Next state is RUN with InstrValid=1, PC unchanged, so the first fetch is at RESET_PC.
- **Redirect priority in RUN/FLUSH:** BranchTaken > Jump > Stall > Halt > sequential.
- **BranchTaken=1:**
  - Next PC = {BranchTarget[31:2],2'b00}.
  - Next state FLUSH, counter=FLUSH_CYCLES, Flush=1, InstrValid=0 from the next cycle.
  - Overrides Stall, because the stalled instruction is on the wrong path.
- **Jump=1** (no branch): same as a branch but with JumpTarget.
- **Misaligned target:** any redirect whose target[1:0]!=0 sets MisalignErr=1; the flag clears only on reset. The redirect still proceeds with the truncated address.
- **Stall=1** (no redirect): PC, InstrValid and state held; counter does not decrement.
- **Halt=1** in RUN (no redirect, no stall):
  - Next state HALTED, PC held, InstrValid=0, Halted=1.
  - HALTED ignores every input except reset.
- **Sequential** (RUN, no event): PC <= PC+4. 32'hFFFF_FFFC wraps to 0. InstrValid stays 1.
- **FLUSH:**
  - Each unstalled cycle, PC <= PC+4 (fetching the target path) and the counter decrements.
  - Flush=1 and InstrValid=0 while counter>1.
  - When the counter reaches 1, the next cycle is RUN with Flush=0 and InstrValid=1.
  - Redirect timing: Flush/InstrValid=0 is visible for exactly FLUSH_CYCLES cycles, starting the cycle after BranchTaken is sampled. PC = target in the first of those cycles.
- **Redirect during FLUSH:** honoured. New target is loaded and the counter reloads to FLUSH_CYCLES; the flush window restarts.
- **Halt during FLUSH:** ignored, because a halt on the wrong path must not stop the core.
- **Stall during FLUSH** (no redirect): PC and counter frozen, Flush remains 1.
- **Data path:** PCPlus4 is combinational: PC+4 with carry discarded.

Test Plan:
1. Reset with RESET_PC=0, idle inputs for 5 cycles:
   - START cycle shows PC=0, InstrValid=0.
   - Then PC=0,4,8,12 with InstrValid=1.
   - Flush=0 throughout.
2. In RUN at PC=0x20, pulse BranchTaken with BranchTarget=0x100 (FLUSH_CYCLES=2):
   - Next cycles PC=0x100, 0x104 with Flush=1, InstrValid=0.
   - Then PC=0x108 with Flush=0, InstrValid=1.
3. BranchTaken, Jump and Stall all asserted in the same cycle, with BranchTarget=0x40 and JumpTarget=0x80:
   - PC becomes 0x40, FLUSH entered.
   - Second BranchTaken (target 0x200) during FLUSH: PC=0x200, flush window restarts for 2 full cycles.
4. Jump to 0x103:
   - PC=0x100, MisalignErr=1.
   - MisalignErr remains 1 after further normal redirects; clears only after reset.
5. PC advanced to 0xFFFF_FFF8 via jump, then run:
   - Sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
   - PCPlus4=0x0 while PC=0xFFFF_FFFC.
6. Halt in RUN at PC=0x30:
   - Halted=1, PC frozen at 0x30, InstrValid=0.
   - Branch/Jump ignored while halted.
   - Halt asserted during FLUSH is ignored.
   - Reset asserted mid-FLUSH returns PC=RESET_PC, Flush=0, state START.
